// File: rtl/muon_pkg.sv
// Shared types, default parameters and helpers for the N-channel muon coincidence detector.
package muon_pkg;

    localparam int unsigned DefNCh       = 4;
    localparam int unsigned DefTsW       = 64;
    localparam int unsigned DefFifoDepth = 16;
    localparam int unsigned DefWinW      = 8;
    localparam int unsigned MaxCh        = 16;

    typedef enum logic [1:0] {
        StIdle,
        StOpen,
        StEval
    } state_e;

    function automatic logic [4:0] popcount(input logic [MaxCh-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MaxCh; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/muon_event_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO succeeds when a pop
// happens in the same cycle.
module muon_event_fifo
    import muon_pkg::*;
#(
    parameter int unsigned WIDTH = DefTsW + DefNCh,
    parameter int unsigned DEPTH = DefFifoDepth
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     push_ok
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        out_valid = count_q != '0;
        full      = count_q == CW'(DEPTH);
        do_pop    = out_valid && pop_ready;
        push_ok   = !full || do_pop;
        do_push   = push && push_ok;
        // Head is forced to zero when empty so the outputs read 0 out of reset.
        out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
        count     = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/muon_coincidence_nch.sv
// N-channel coincidence detector: timestamps the first enabled edge, collects hits over
// a window, qualifies by M-of-N and queues {timestamp, mask} for readout.
module muon_coincidence_nch
    import muon_pkg::*;
#(
    parameter int unsigned N_CH       = DefNCh,
    parameter int unsigned TS_W       = DefTsW,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth,
    parameter int unsigned WIN_W      = DefWinW
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CH-1:0]               hit_in,
    input  logic [N_CH-1:0]               cfg_ch_enable,
    input  logic [WIN_W-1:0]              cfg_window,
    input  logic [$clog2(N_CH+1)-1:0]     cfg_min_hits,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TS_W-1:0]               out_ts,
    output logic [N_CH-1:0]               out_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          event_pulse,
    output logic [15:0]                   drop_cnt
);

    localparam int unsigned MW = $clog2(N_CH + 1);
    localparam int unsigned EW = TS_W + N_CH;

    state_e            state_q, state_d;
    logic [N_CH-1:0]   hit_prev_q;
    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [TS_W-1:0]   counter_q;
    logic [TS_W-1:0]   t0_q, t0_d;
    logic [WIN_W-1:0]  timer_q, timer_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [MW-1:0]     min_q, min_d;
    logic [MaxCh-1:0]  mask_ext;
    logic [4:0]        threshold;
    logic              qualified;
    logic              open_win;
    logic              push;
    logic              push_ok;
    logic              drop_inc;
    logic              event_pulse_q;
    logic [15:0]       drop_cnt_q;
    logic [EW-1:0]     head;

    assign rise = hit_in & ~hit_prev_q & cfg_ch_enable;

    always_comb begin
        mask_ext               = '0;
        mask_ext[N_CH-1:0]     = mask_q;
        // M == 0 still needs at least one hit; M > N_CH can never be reached.
        threshold = (min_q == '0) ? 5'd1 : 5'(min_q);
        qualified = (state_q == StEval) && (popcount(mask_ext) >= threshold);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StEval: begin
                if (rise != '0) begin
                    state_d = (cfg_window == '0) ? StEval : StOpen;
                end else begin
                    state_d = StIdle;
                end
            end
            StOpen: begin
                if (timer_q == win_q - WIN_W'(1)) begin
                    state_d = StEval;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // A new window may open in the evaluation cycle, so there is no dead time.
        open_win = ((state_q == StIdle) || (state_q == StEval)) && (rise != '0);
        push     = qualified && push_ok;
        drop_inc = qualified && !push_ok;
    end

    always_comb begin
        t0_d    = t0_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        win_d   = win_q;
        min_d   = min_q;
        if (open_win) begin
            t0_d    = counter_q;
            mask_d  = rise;
            timer_d = '0;
            win_d   = cfg_window;
            min_d   = cfg_min_hits;
        end else if (state_q == StOpen) begin
            mask_d  = mask_q | rise;
            timer_d = timer_q + WIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_prev_q    <= '1;
            counter_q     <= '0;
            t0_q          <= '0;
            mask_q        <= '0;
            timer_q       <= '0;
            win_q         <= '0;
            min_q         <= '0;
            drop_cnt_q    <= '0;
            event_pulse_q <= 1'b0;
        end else begin
            hit_prev_q    <= hit_in;
            counter_q     <= counter_q + TS_W'(1);
            t0_q          <= t0_d;
            mask_q        <= mask_d;
            timer_q       <= timer_d;
            win_q         <= win_d;
            min_q         <= min_d;
            event_pulse_q <= push;
            if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    muon_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({t0_q, mask_q}),
        .pop_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .push_ok   (push_ok)
    );

    assign out_ts      = head[EW-1:N_CH];
    assign out_mask    = head[N_CH-1:0];
    assign event_pulse = event_pulse_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
